// File: rtl/stream_arb_mux.sv
// Arbitrates M valid/ready streams (fixed select or round-robin) onto one registered output.
// One cycle from input handshake to out_valid; in_ready follows downstream space, so a full register stalls every input.
module stream_arb_mux #(
  parameter int N     = 32,
  parameter int M     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M*N-1:0]   in_data,
  input  logic [M-1:0]     in_valid,
  output logic [M-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_src
);

  localparam int VW = 2**SEL_W;

  logic [VW-1:0]    valid_pad;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] rr_cand;
  logic             rr_found;
  int               scan;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             can_accept;
  logic             xfer_in;
  logic [N-1:0]     grant_dat;

  // Indices at or above M select zero-padded bits, so an out-of-range select never grants.
  assign valid_pad = VW'(in_valid);

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    scan     = 0;
    for (int k = 1; k <= M; k++) begin
      scan    = (int'(last) + k) % M;
      rr_cand = SEL_W'(scan);
      if (!rr_found && valid_pad[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign grant      = mode ? rr_idx : select;
  assign grant_vld  = mode ? rr_found : valid_pad[select];
  assign can_accept = ~out_valid | out_ready;
  assign in_ready   = (grant_vld && can_accept && !rst) ? ({{(M-1){1'b0}}, 1'b1} << grant) : '0;
  assign xfer_in    = grant_vld && can_accept && !rst;

  always_comb begin
    grant_dat = '0;
    for (int i = 0; i < M; i++) begin
      if (grant == SEL_W'(i)) grant_dat = in_data[i*N +: N];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      last      <= SEL_W'(M-1);
    end else begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_data  <= grant_dat;
        out_src   <= grant;
        if (mode) last <= grant;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux with N=32, M=4: reset, fixed select, round-robin, backpressure, mode switch.
module tb_stream_arb_mux;
  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         mode;
  logic [1:0]   select;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_src;

  int errors = 0;
  int checks = 0;

  stream_arb_mux #(.N(32), .M(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .select(select), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_src(out_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] src);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_src"}, {30'd0, out_src}, {30'd0, src});
    chk({tag, "_data"}, out_data, 32'hA0 + {30'd0, src});
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; select = 2'd0; in_valid = 4'b0000; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + i;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    rst = 1'b0;

    // Load a word, then reset while it is held
    select = 2'd2; in_valid = 4'b1111;
    #1 chk("pre_rst_in_ready", {28'd0, in_ready}, 32'h4);
    step();
    chk_out("pre_rst", 2'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", out_data, 32'd0);
    chk("async_rst_src", {30'd0, out_src}, 32'd0);
    chk("in_rst_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0; in_valid = 4'b0000;
    #1 chk("idle_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Fixed mode
    out_ready = 1'b1; select = 2'd2; in_valid = 4'b1111;
    #1 chk("fix_in_ready", {28'd0, in_ready}, 32'h4);
    step();
    chk_out("fix_sel2", 2'd2);
    select = 2'd3; in_valid = 4'b0111;
    #1 chk("fix_sel3_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    chk("fix_sel3_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fix_hold_data", out_data, 32'hA2);

    // Round-robin from the reset pointer: 0,1,2,3,0,1
    mode = 1'b1; in_valid = 4'b1111;
    #1 chk("rr_first_in_ready", {28'd0, in_ready}, 32'h1);
    step(); chk_out("rr0", 2'd0);
    step(); chk_out("rr1", 2'd1);
    step(); chk_out("rr2", 2'd2);
    step(); chk_out("rr3", 2'd3);
    step(); chk_out("rr4", 2'd0);
    step(); chk_out("rr5", 2'd1);

    // Fixed transfers must not move the pointer (last=1)
    mode = 1'b0; select = 2'd0;
    #1 chk("sw_fix_in_ready", {28'd0, in_ready}, 32'h1);
    step(); chk_out("sw_fix0", 2'd0);
    step(); chk_out("sw_fix1", 2'd0);
    mode = 1'b1;
    #1 chk("sw_rr_in_ready", {28'd0, in_ready}, 32'h4);
    step(); chk_out("sw_rr", 2'd2);

    // Skip idle channels; restart from the reset pointer
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 4'b1010;
    #1 chk("skip_in_ready", {28'd0, in_ready}, 32'h2);
    step(); chk_out("skip_a", 2'd1);
    step(); chk_out("skip_b", 2'd3);
    step(); chk_out("skip_c", 2'd1);
    in_valid = 4'b0010;
    #1 chk("skip_drop_in_ready", {28'd0, in_ready}, 32'h2);
    step(); chk_out("skip_d", 2'd1);

    // Backpressure: hold for three cycles, then replace with no bubble
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", {28'd0, in_ready}, 32'd0);
      step(); chk_out("bp_hold", 2'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", {28'd0, in_ready}, 32'h4);
    step(); chk_out("bp_replace", 2'd2);
    in_valid = 4'b0000;
    step();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
